// File: rtl/lsu_store_buffer_if.sv
// Core-side store/load/fence handshake and the shared data-memory port of the LSU store buffer.
// The master modport belongs to the core or bench, and the slave modport belongs to the buffer.
interface lsu_store_buffer_if;
   logic        i_st_req;
   logic [2:0]  i_st_func3;
   logic [31:0] i_st_addr;
   logic [31:0] i_st_data;
   logic        o_st_ready;

   logic        i_ld_req;
   logic [2:0]  i_ld_func3;
   logic [31:0] i_ld_addr;
   logic        o_ld_stall;

   logic        i_fence;
   logic        o_fence_busy;

   logic        o_mem_wren;
   logic [2:0]  o_mem_func3;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_data;

   modport master (
      output i_st_req, i_st_func3, i_st_addr, i_st_data,
      output i_ld_req, i_ld_func3, i_ld_addr,
      output i_fence,
      input  o_st_ready, o_ld_stall, o_fence_busy,
      input  o_mem_wren, o_mem_func3, o_mem_addr, o_mem_data
   );

   modport slave (
      input  i_st_req, i_st_func3, i_st_addr, i_st_data,
      input  i_ld_req, i_ld_func3, i_ld_addr,
      input  i_fence,
      output o_st_ready, o_ld_stall, o_fence_busy,
      output o_mem_wren, o_mem_func3, o_mem_addr, o_mem_data
   );
endinterface

// File: rtl/lsu_store_buffer.sv
// Circular store buffer between the core and a single-ported data memory.
// A granted load owns the port, and buffered stores drain in order whenever the port is otherwise free.
module lsu_store_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   lsu_store_buffer_if.slave            bus,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_empty
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [2:0]  func3;
      logic [31:0] addr;
      logic [31:0] data;
   } entry_t;

   entry_t         entries [DEPTH];
   entry_t         head;
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic [PW-1:0]  slot_rel;
   logic [DEPTH-1:0] slot_valid;
   logic           hazard;
   logic           ld_grant;
   logic           push;
   logic           pop;
   logic [29:0]    ld_start_w;
   logic [29:0]    ld_end_w;

   // Word index of the last byte of an access; size 1/2/4 comes from func3[1:0].
   function automatic logic [29:0] end_word(input logic [31:0] addr, input logic [1:0] size_code);
      logic [1:0] last_off;
      last_off = {size_code[1], size_code[1] | size_code[0]};
      return addr[31:2] + {29'd0, ({1'b0, addr[1:0]} + {1'b0, last_off}) > 3'd3};
   endfunction

   // A span never covers more than two words, so comparing its first and last words is exact.
   function automatic logic words_overlap(input logic [29:0] a_s, input logic [29:0] a_e,
                                          input logic [29:0] b_s, input logic [29:0] b_e);
      return (a_s == b_s) || (a_s == b_e) || (a_e == b_s) || (a_e == b_e);
   endfunction

   assign ld_start_w = bus.i_ld_addr[31:2];
   assign ld_end_w   = end_word(bus.i_ld_addr, bus.i_ld_func3[1:0]);

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      slot_rel   = '0;
      slot_valid = '0;
      hazard     = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_rel      = PW'(i) - rd_ptr;
         slot_valid[i] = ({1'b0, slot_rel} < count);
         if (slot_valid[i] &&
             words_overlap(entries[i].addr[31:2],
                           end_word(entries[i].addr, entries[i].func3[1:0]),
                           ld_start_w, ld_end_w)) begin
            hazard = 1'b1;
         end
      end
   end

   assign head             = entries[rd_ptr];
   assign bus.o_ld_stall   = bus.i_ld_req && hazard;
   assign ld_grant         = bus.i_ld_req && !hazard;
   assign bus.o_st_ready   = (count < CW'(DEPTH)) && !bus.i_fence;
   assign push             = bus.i_st_req && bus.o_st_ready;
   assign bus.o_fence_busy = bus.i_fence && (count != '0);
   assign o_count          = count;
   assign o_empty          = (count == '0);

   // A stalled load leaves the port to the drain, which is what eventually clears its stall.
   always_comb begin
      bus.o_mem_wren  = 1'b0;
      bus.o_mem_func3 = bus.i_ld_func3;
      bus.o_mem_addr  = bus.i_ld_addr;
      bus.o_mem_data  = '0;
      pop             = 1'b0;
      if (!ld_grant && (count != '0)) begin
         bus.o_mem_wren  = 1'b1;
         bus.o_mem_func3 = head.func3;
         bus.o_mem_addr  = head.addr;
         bus.o_mem_data  = head.data;
         pop             = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments, so every reader sees the pre-edge value.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: payload storage has no reset; an entry is only ever read while count marks it valid.
   always_ff @(posedge i_clk) begin
      if (push) begin
         entries[wr_ptr] <= '{func3: bus.i_st_func3, addr: bus.i_st_addr, data: bus.i_st_data};
      end
   end
endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed, self-checking bench for lsu_store_buffer with DEPTH=4.
// Inputs are driven 1 ns after each rising edge, and outputs are sampled 1 ns later.
module tb_lsu_store_buffer;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] count;
   logic       empty;
   int         n_vec = 0;
   int         n_err = 0;
   int         busy_cycles;
   logic [31:0] exp_q [$];
   logic [31:0] exp_word;

   always #5 clk = ~clk;

   lsu_store_buffer_if sb_if ();

   lsu_store_buffer #(.DEPTH(DEPTH)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .bus     (sb_if),
      .o_count (count),
      .o_empty (empty)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      sb_if.i_st_req   = 1'b1;
      sb_if.i_st_func3 = f3;
      sb_if.i_st_addr  = a;
      sb_if.i_st_data  = d;
   endtask

   task automatic no_store();
      sb_if.i_st_req = 1'b0;
   endtask

   task automatic load(input logic [2:0] f3, input logic [31:0] a);
      sb_if.i_ld_req   = 1'b1;
      sb_if.i_ld_func3 = f3;
      sb_if.i_ld_addr  = a;
   endtask

   task automatic no_load();
      sb_if.i_ld_req = 1'b0;
   endtask

   task automatic check_write(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d);
      check({tag, "_wren"},  32'(sb_if.o_mem_wren), 32'd1);
      check({tag, "_func3"}, 32'(sb_if.o_mem_func3), 32'(f3));
      check({tag, "_addr"},  sb_if.o_mem_addr, a);
      check({tag, "_data"},  sb_if.o_mem_data, d);
   endtask

   initial begin
      sb_if.i_st_req = 1'b0; sb_if.i_st_func3 = 3'd0; sb_if.i_st_addr = '0; sb_if.i_st_data = '0;
      sb_if.i_ld_req = 1'b0; sb_if.i_ld_func3 = 3'd0; sb_if.i_ld_addr = '0;
      sb_if.i_fence  = 1'b0;

      // Reset values, with i_fence observed through o_st_ready, and a store ignored while reset is held.
      #1 rst = 1'b1;
      #1;
      check("rst_count",      32'(count), 32'd0);
      check("rst_empty",      32'(empty), 32'd1);
      check("rst_wren",       32'(sb_if.o_mem_wren), 32'd0);
      check("rst_stall",      32'(sb_if.o_ld_stall), 32'd0);
      check("rst_fence_busy", 32'(sb_if.o_fence_busy), 32'd0);
      check("rst_st_ready",   32'(sb_if.o_st_ready), 32'd1);
      sb_if.i_fence = 1'b1;
      #1;
      check("rst_st_ready_fence", 32'(sb_if.o_st_ready), 32'd0);
      check("rst_fence_busy_f",   32'(sb_if.o_fence_busy), 32'd0);
      sb_if.i_fence = 1'b0;
      store(3'b010, 32'h0000_1234, 32'h1111_1111);
      tick();
      check("rst_push_ignored", 32'(count), 32'd0);
      no_store();
      rst = 1'b0;
      tick();

      // A single SW drains on the cycle after it is accepted.
      store(3'b010, 32'h0000_2000, 32'hDEAD_BEEF);
      #1;
      check("sw_accept_ready", 32'(sb_if.o_st_ready), 32'd1);
      check("sw_no_same_cycle", 32'(sb_if.o_mem_wren), 32'd0);
      tick();
      no_store();
      #1;
      check("sw_count1", 32'(count), 32'd1);
      check_write("sw_drain", 3'b010, 32'h0000_2000, 32'hDEAD_BEEF);
      tick();
      check("sw_count0", 32'(count), 32'd0);
      check("sw_idle_wren", 32'(sb_if.o_mem_wren), 32'd0);

      // A load on a non-hazard address holds the port while the buffer fills.
      load(3'b010, 32'h0000_3000);
      store(3'b010, 32'h0000_1000, 32'h1111_1111); #1;
      check("fill0_wren", 32'(sb_if.o_mem_wren), 32'd0);
      check("fill0_addr", sb_if.o_mem_addr, 32'h0000_3000);
      tick();
      store(3'b001, 32'h0000_1006, 32'hAAAA_2222); #1;
      check("fill1_stall", 32'(sb_if.o_ld_stall), 32'd0);
      tick();
      store(3'b000, 32'h0000_1009, 32'hBBBB_BB33); tick();
      store(3'b010, 32'h0000_100C, 32'h4444_4444); tick();
      store(3'b010, 32'h0000_1010, 32'h5555_5555); #1;
      check("full_count", 32'(count), 32'd4);
      check("full_ready", 32'(sb_if.o_st_ready), 32'd0);
      check("full_wren",  32'(sb_if.o_mem_wren), 32'd0);
      tick();
      check("full_hold_count", 32'(count), 32'd4);
      no_store();
      no_load();
      #1;
      check_write("fifo0", 3'b010, 32'h0000_1000, 32'h1111_1111); tick();
      check_write("fifo1", 3'b001, 32'h0000_1006, 32'hAAAA_2222); tick();
      check_write("fifo2", 3'b000, 32'h0000_1009, 32'hBBBB_BB33); tick();
      check_write("fifo3", 3'b010, 32'h0000_100C, 32'h4444_4444); tick();
      check("fifo_done_count", 32'(count), 32'd0);
      check("fifo_done_wren",  32'(sb_if.o_mem_wren), 32'd0);

      // SB 0x2003 overlaps LW 0x2000, and the stall clears once the SB drains.
      store(3'b000, 32'h0000_2003, 32'h0000_00A5); tick();
      no_store();
      load(3'b010, 32'h0000_2000); #1;
      check("sb_lw_stall", 32'(sb_if.o_ld_stall), 32'd1);
      check_write("sb_lw_drain", 3'b000, 32'h0000_2003, 32'h0000_00A5);
      tick();
      check("sb_lw_stall_clear", 32'(sb_if.o_ld_stall), 32'd0);
      check("sb_lw_load_port",   sb_if.o_mem_addr, 32'h0000_2000);
      check("sb_lw_load_wren",   32'(sb_if.o_mem_wren), 32'd0);
      no_load();

      // The same SB against LW 0x2004 is a different word, so the load proceeds.
      store(3'b000, 32'h0000_2003, 32'h0000_005A); tick();
      no_store();
      load(3'b010, 32'h0000_2004); #1;
      check("sb_lw4_stall", 32'(sb_if.o_ld_stall), 32'd0);
      check("sb_lw4_wren",  32'(sb_if.o_mem_wren), 32'd0);
      check("sb_lw4_addr",  sb_if.o_mem_addr, 32'h0000_2004);
      tick();
      check("sb_lw4_kept", 32'(count), 32'd1);
      no_load(); #1;
      check_write("sb_lw4_drain", 3'b000, 32'h0000_2003, 32'h0000_005A);
      tick();

      // A misaligned SH at 0x2007 ends in word 0x2008, so an LB at 0x2008 must stall.
      store(3'b001, 32'h0000_2007, 32'hBEEF_1234); tick();
      no_store();
      load(3'b000, 32'h0000_2008); #1;
      check("sh_lb_stall", 32'(sb_if.o_ld_stall), 32'd1);
      check_write("sh_lb_drain", 3'b001, 32'h0000_2007, 32'hBEEF_1234);
      tick();
      check("sh_lb_stall_clear", 32'(sb_if.o_ld_stall), 32'd0);
      no_load();

      // Occupancy stays at 2 with a push and a pop every cycle while the pointers wrap.
      load(3'b010, 32'h0000_3000);
      store(3'b010, 32'h0000_4000, 32'hA000_0000); exp_q.push_back(32'hA000_0000); tick();
      store(3'b010, 32'h0000_4004, 32'hB000_0000); exp_q.push_back(32'hB000_0000); tick();
      no_load();
      for (int i = 0; i < 10; i++) begin
         store(3'b010, 32'h0000_4100 + 32'(4 * i), 32'hC000_0000 + 32'(i));
         #1;
         exp_word = exp_q.pop_front();
         check($sformatf("steady%0d_count", i), 32'(count), 32'd2);
         check($sformatf("steady%0d_data", i), sb_if.o_mem_data, exp_word);
         exp_q.push_back(32'hC000_0000 + 32'(i));
         tick();
      end
      no_store(); #1;
      check("steady_end_count", 32'(count), 32'd2);
      for (int i = 0; i < 2; i++) begin
         exp_word = exp_q.pop_front();
         check($sformatf("steady_tail%0d", i), sb_if.o_mem_data, exp_word);
         tick();
      end
      check("steady_empty", 32'(empty), 32'd1);

      // Reset with three entries pending discards them with no write, even in the reset cycle.
      load(3'b010, 32'h0000_3000);
      store(3'b010, 32'h0000_5000, 32'h0000_0001); tick();
      store(3'b010, 32'h0000_5004, 32'h0000_0002); tick();
      store(3'b010, 32'h0000_5008, 32'h0000_0003); tick();
      no_store();
      check("pre_rst_count", 32'(count), 32'd3);
      no_load();
      rst = 1'b1; #1;
      check("rst_mid_wren",  32'(sb_if.o_mem_wren), 32'd0);
      check("rst_mid_count", 32'(count), 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("post_rst%0d_wren", i), 32'(sb_if.o_mem_wren), 32'd0);
         tick();
      end

      // A fence with two entries pending stays busy for exactly two cycles.
      load(3'b010, 32'h0000_3000);
      store(3'b010, 32'h0000_6000, 32'h0000_0006); tick();
      store(3'b010, 32'h0000_6004, 32'h0000_0007); tick();
      no_store();
      no_load();
      sb_if.i_fence = 1'b1;
      #1;
      check("fence_ready", 32'(sb_if.o_st_ready), 32'd0);
      check_write("fence_drain0", 3'b010, 32'h0000_6000, 32'h0000_0006);
      busy_cycles = 0;
      for (int c = 0; c < 8; c++) begin
         if (sb_if.o_fence_busy) busy_cycles++;
         tick();
      end
      check("fence_busy_cycles", 32'(busy_cycles), 32'd2);
      check("fence_empty", 32'(empty), 32'd1);
      sb_if.i_fence = 1'b0; #1;
      check("fence_release_ready", 32'(sb_if.o_st_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/lsu_store_buffer.md
LSU_STORE_BUFFER -- requirements
Module: lsu_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, 2..16), number of buffered store entries.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports i_st_req/i_st_func3/i_st_addr/i_st_data  input  1/3/32/32  store request from core: SB=000, SH=001, SW=010.
REQ-005 SHALL have port o_st_ready  output  1  store accepted on an edge where i_st_req and o_st_ready are both high.
REQ-006 SHALL have ports i_ld_req/i_ld_func3/i_ld_addr  input  1/3/32  load request from core.
REQ-007 SHALL have port o_ld_stall  output  1  load must be held; o_mem_data read is not valid.
REQ-008 SHALL have port i_fence  input  1  drain request; o_fence_busy  output  1  buffer not yet empty.
REQ-009 SHALL have ports o_mem_wren/o_mem_func3/o_mem_addr/o_mem_data  output  1/3/32/32  single shared port to data memory (write, size, address, store data).
REQ-010 SHALL have ports o_count  output  $clog2(DEPTH+1)  occupied entries; o_empty  output  1  (o_count==0).

Function
REQ-011 SHALL hold entries {func3, addr, data} in a circular FIFO with write/read pointers wrapping modulo DEPTH.
REQ-012 SHALL drive o_st_ready = (o_count<DEPTH) && !i_fence; no same-cycle pass-through when full.
REQ-013 SHALL define load hazard: any valid entry whose byte span [addr, addr+size-1] overlaps any word touched by the load span (compare addr[31:2] of start and end bytes of both spans; size 1/2/4 from func3[1:0]).
REQ-014 SHALL drive o_ld_stall = i_ld_req && hazard, combinationally.
REQ-015 Port arbitration: i_ld_req && !o_ld_stall -> load owns port: o_mem_addr=i_ld_addr, o_mem_func3=i_ld_func3, o_mem_wren=0, no pop.
REQ-016 Otherwise, if o_count>0 -> drain head: o_mem_addr/func3/data = head fields, o_mem_wren=1, pop on the same edge (one store per cycle).
REQ-017 Otherwise o_mem_wren=0, o_mem_addr=i_ld_addr, o_mem_func3=i_ld_func3, o_mem_data=0.
REQ-018 A stalled load SHALL NOT block draining; the stall therefore clears after at most DEPTH cycles.
REQ-019 Simultaneous push and pop SHALL leave o_count unchanged; push-only +1, pop-only -1; o_count never exceeds DEPTH nor underflows.
REQ-020 A store accepted in cycle N is visible to hazard checks from cycle N+1 and is drained no earlier than cycle N+1.
REQ-021 i_st_req && i_ld_req in the same cycle: store is accepted per REQ-012; load is not checked against it (core guarantees exclusivity; bench asserts it).
REQ-022 o_fence_busy = i_fence && (o_count!=0); draining continues per REQ-016.
REQ-023 Stores SHALL reach memory in acceptance order, with func3/addr/data unmodified, including misaligned addresses.

Reset
REQ-024 While i_rst high: pointers=0, o_count=0, o_empty=1, o_mem_wren=0, o_ld_stall=0, o_fence_busy=0, o_st_ready=!i_fence.
REQ-025 Reset mid-operation SHALL discard all pending entries with no memory write, including in the cycle reset asserts.
REQ-026 Entry payload registers need not be reset; only valid state is reset.

Verification
REQ-027 Reset, then SW addr 0x2000 data 0xDEADBEEF, no load -> o_mem_wren=1 next cycle with addr 0x2000, func3 010, data 0xDEADBEEF; o_count 1->0.
REQ-028 Hold i_ld_req on a non-hazard address while pushing 4 stores -> o_st_ready=0 at count 4, no writes; drop load -> 4 writes in FIFO order on 4 consecutive cycles.
REQ-029 SB 0x2003 buffered, then LW 0x2000 -> o_ld_stall=1 for 1 cycle while SB drains, then 0; LW 0x2004 with the same SB buffered -> no stall.
REQ-030 Misaligned SH 0x2007 buffered, then LB 0x2008 -> stall (end-word overlap).
REQ-031 Count 2 with a push each cycle and no load -> count stays 2; pointers wrap past DEPTH-1 correctly over 10 cycles.
REQ-032 3 entries buffered, assert i_rst for one cycle -> o_count=0, no o_mem_wren pulse afterwards; i_fence with 2 entries -> o_fence_busy high exactly 2 cycles.
